lsu_dmem: RTL and testbench
===========================

// Module: lsu_dmem
// PURPOSE
//  Data-memory responder for the LSU: services its store (wr_*) and load (rd_*) requests.
//  Word-addressed SRAM array with a single port, fronted by an in-order store buffer (FIFO).
//  Loads return data one cycle after rd_en, matching the LSU EX->WB timing.
//  stall_out feeds the hazard detection unit to freeze the pipeline when a request cannot be taken.
// PARAMETERS
//  ADDR_W    10  word-index width; array depth is 2**ADDR_W x 32 bits
//  SB_DEPTH  4   store-buffer entries; power of two, >= 2
// PORTS
//  clk        in   1       clock; all state updates on the rising edge
//  rst        in   1       asynchronous, active-low reset
//  wr_en      in   1       store request from LSU execute
//  wr_addr    in   32      store byte address; bits [1:0] ignored
//  wr_data    in   32      store data, full word
//  rd_en      in   1       load request from LSU execute
//  rd_addr    in   32      load byte address; bits [1:0] ignored
//  rd_data    out  32      load data, valid the cycle after an accepted rd_en
//  stall_out  out  1       request not accepted this cycle; LSU holds and re-presents it
//  sb_count   out  $clog2(SB_DEPTH)+1  current store-buffer occupancy (debug/verif)
// BEHAVIOUR
//  Reset (rst=0, async): store buffer empty, sb_count=0, rd_data=0, stall_out=0.
//   Array contents are not cleared. Pending stores are discarded on reset mid-operation.
//  Address: index = addr[ADDR_W+1:2]; higher bits are ignored, so out-of-range addresses alias.
//  Store: wr_en && !full -> enqueue {index,data} at tail on the same edge.
//   If the buffer is full, the store is not accepted and stall_out=1.
//  Array port: one access per cycle. A load has priority over drain.
//   Drain: buffer non-empty and the port is not used by a load -> head written to array, head popped.
//  Simultaneous enqueue and drain: count is unchanged. Pointers wrap modulo SB_DEPTH.
//  A full-buffer condition is evaluated from registered count only.
//   A drain in the same cycle does not admit the store; it is accepted on the next cycle.
//  Load: accepted rd_en -> rd_data is registered on the next edge. Latency is 1 cycle.
//   rd_data holds its last value when no load is accepted.
//  wr_en and rd_en in the same cycle: the load sees the buffer state before that store; the store is enqueued.
//  stall_out is combinational from registered state and the current rd_en/rd_addr:
//   stall_out = full | load_block, where load_block is defined under CONFIGURATION.
//  The array is read through an inferred synchronous-read RAM; the read port and the drain write are never concurrent.
// CONFIGURATION
//  Macro DMEM_FWD_EN (store-to-load forwarding):
//   Defined: on rd_en, every valid buffer entry is compared against the load index.
//    The youngest matching entry's data is returned next cycle instead of array data.
//    load_block=0; a load is never stalled.
//   Undefined: if the load index matches any valid buffer entry, load_block=1.
//    The load is not performed that cycle, and the port is free, so the head drains.
//    The load completes the cycle after no entry matches.
// TESTING
//  1 store 0xDEADBEEF @0x40; idle 4 cyc; load @0x40 -> next cycle rd_data=0xDEADBEEF, stall_out=0 throughout
//  2 store 0x11111111 @0x80, then load @0x80 on the next cycle -> FWD_EN: rd_data=0x11111111 1 cyc later, no stall;
//    without: stall_out=1 until the entry drains, then rd_data=0x11111111
//  3 stores 0x0000000A then 0x0000000B @0x84 back-to-back, immediate load @0x84 -> FWD_EN: 0x0000000B (youngest);
//    without: stall until both drained, then 0x0000000B
//  4 4 stores @0x100..0x10C while rd_en held continuously to 0x200 -> sb_count=4, stall_out=1 on a 5th store;
//    release rd_en -> drain, 5th accepted; later loads return each stored value
//  5 queue 3 stores (sb_count=3), pulse rst low mid-drain -> sb_count=0, stall_out=0, rd_data=0 immediately (async)
//  6 ADDR_W=10: store 0x5A5A5A5A @0x1000; drain; load @0x0000 -> rd_data=0x5A5A5A5A (alias)

Source files
------------

// File: rtl/lsu_dmem_if.sv
// LSU <-> data-memory request/response bundle: store and load requests in, load data,
// stall and store-buffer occupancy out.
interface lsu_dmem_if #(
  parameter int SB_DEPTH = 4
);
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             rd_en;
  logic [31:0]      rd_addr;
  logic [31:0]      rd_data;
  logic             stall_out;
  logic [CNT_W-1:0] sb_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, stall_out, sb_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, stall_out, sb_count
  );
endinterface

// File: rtl/lsu_dmem.sv
// Single-port word-addressed data memory behind an in-order store buffer; 1-cycle loads.
// Optional store-to-load forwarding is enabled by defining DMEM_FWD_EN.
module lsu_dmem #(
  parameter int ADDR_W   = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  lsu_dmem_if.slave bus
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [ADDR_W-1:0] idx_t;
  typedef struct packed {
    idx_t        idx;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t        sb_q [SB_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] ram_q;
  logic [31:0] hold_q;
  logic        rd_vld_q;

  idx_t rd_idx, wr_idx;
  logic full, hit, load_block, load_go, wr_acc, drain;
  logic [31:0] rd_word;

  // Bits outside the word index are ignored; addresses alias across the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.wr_addr[31:ADDR_W+2], bus.wr_addr[1:0],
                              bus.rd_addr[31:ADDR_W+2], bus.rd_addr[1:0]};

  assign rd_idx = bus.rd_addr[ADDR_W+1:2];
  assign wr_idx = bus.wr_addr[ADDR_W+1:2];

`ifdef DMEM_FWD_EN
  logic [31:0] hit_data;
  logic        fwd_sel_q;
  logic [31:0] fwd_data_q;
`endif

  // Walk oldest -> youngest so the last match seen is the youngest store.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    hit = 1'b0;
`ifdef DMEM_FWD_EN
    hit_data = '0;
`endif
    for (int k = 0; k < SB_DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) && (sb_q[head_q + PTR_W'(k)].idx == rd_idx)) begin
        hit = 1'b1;
`ifdef DMEM_FWD_EN
        hit_data = sb_q[head_q + PTR_W'(k)].data;
`endif
      end
    end
  end

`ifdef DMEM_FWD_EN
  assign load_block = 1'b0;
`else
  assign load_block = bus.rd_en & hit;
`endif

  // Full is judged on registered occupancy only; a same-cycle drain does not admit a store.
  assign full    = (count_q == CNT_W'(SB_DEPTH));
  assign wr_acc  = bus.wr_en & ~full;
  assign load_go = bus.rd_en & ~load_block;
  assign drain   = (count_q != '0) & ~load_go;

  assign bus.stall_out = full | load_block;
  assign bus.sb_count  = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (wr_acc) tail_q <= tail_q + 1'b1;
      if (drain)  head_q <= head_q + 1'b1;
      case ({wr_acc, drain})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (wr_acc) sb_q[tail_q] <= '{idx: wr_idx, data: bus.wr_data};
  end

  // NOTE: the array and its read register carry no reset so they map onto a plain SRAM macro.
  always_ff @(posedge clk) begin
    if (drain)   mem[sb_q[head_q].idx] <= sb_q[head_q].data;
    if (load_go) ram_q <= mem[rd_idx];
  end

  always_comb begin
    rd_word = ram_q;
`ifdef DMEM_FWD_EN
    if (fwd_sel_q) rd_word = fwd_data_q;
`endif
  end

  // rd_data shows fresh load data for one cycle, then hold_q keeps it until the next load.
  assign bus.rd_data = rd_vld_q ? rd_word : hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_q   <= 1'b0;
      hold_q     <= '0;
`ifdef DMEM_FWD_EN
      fwd_sel_q  <= 1'b0;
      fwd_data_q <= '0;
`endif
    end else begin
      rd_vld_q <= load_go;
      hold_q   <= bus.rd_data;
`ifdef DMEM_FWD_EN
      if (load_go) begin
        fwd_sel_q  <= hit;
        fwd_data_q <= hit_data;
      end
`endif
    end
  end
endmodule

// File: tb/tb_lsu_dmem.sv
// Scoreboard bench for lsu_dmem: directed stores/loads push expected load data; a monitor
// pops and compares one cycle after each accepted load.
module tb_lsu_dmem;
  localparam int ADDR_W   = 10;
  localparam int SB_DEPTH = 4;
`ifdef DMEM_FWD_EN
  localparam int HAZ_WAIT = 0;
`else
  localparam int HAZ_WAIT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_dmem_if #(.SB_DEPTH(SB_DEPTH)) bus ();

  lsu_dmem #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic        ld_chk   = 1'b0;
  logic        pend     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: note an accepted checked load just before the edge, compare on the next negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL load_data: got 0x%08h with no expected entry queued", bus.rd_data);
        end else begin
          check("load_data", bus.rd_data, exp_q.pop_front());
        end
        pend = 1'b0;
      end
      #4;
      pend = ld_chk & bus.rd_en & ~bus.stall_out & rst;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    #3;
    check("store_stall", 32'(bus.stall_out), 32'd0);
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic load(input string name, input logic [31:0] addr, input logic [31:0] exp,
                      input int exp_wait);
    int waits;
    exp_q.push_back(exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    ld_chk      = 1'b1;
    waits       = 0;
    #3;
    while (bus.stall_out && waits < 20) begin
      waits++;
      cyc();
      #3;
    end
    check({name, "_wait"}, 32'(waits), 32'(exp_wait));
    cyc();
    bus.rd_en = 1'b0;
    ld_chk    = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;

    // Reset state
    #3;
    check("rst_sb_count", 32'(bus.sb_count), 32'd0);
    check("rst_stall", 32'(bus.stall_out), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // 1: store, let it drain, load back
    store(32'h40, 32'hDEADBEEF);
    check("t1_count_after_store", 32'(bus.sb_count), 32'd1);
    idle(4);
    check("t1_count_drained", 32'(bus.sb_count), 32'd0);
    load("t1", 32'h40, 32'hDEADBEEF, 0);

    // 2: load right behind a store to the same word
    store(32'h80, 32'h11111111);
    load("t2", 32'h80, 32'h11111111, HAZ_WAIT);

    // 3: two stores to one word, then load must see the younger
    store(32'h84, 32'h0000000A);
    store(32'h84, 32'h0000000B);
    load("t3", 32'h84, 32'h0000000B, HAZ_WAIT);
    idle(2);

    // 4: continuous loads starve the drain until the buffer fills
    bus.rd_addr = 32'h200;
    bus.rd_en   = 1'b1;
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i));
    check("t4_count_full", 32'(bus.sb_count), 32'd4);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 32'h110;
    bus.wr_data = 32'hA0000004;
    #3;
    check("t4_stall_full", 32'(bus.stall_out), 32'd1);
    cyc();
    bus.rd_en = 1'b0;
    #3;
    check("t4_stall_drain_cycle", 32'(bus.stall_out), 32'd1);
    check("t4_count_still_full", 32'(bus.sb_count), 32'd4);
    cyc();
    #3;
    check("t4_stall_released", 32'(bus.stall_out), 32'd0);
    check("t4_count_after_drain", 32'(bus.sb_count), 32'd3);
    cyc();
    bus.wr_en = 1'b0;
    idle(5);
    check("t4_count_empty", 32'(bus.sb_count), 32'd0);
    for (int i = 0; i < 5; i++) load("t4", 32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i), 0);

    // 5: async reset with stores pending
    bus.rd_addr = 32'h100;
    bus.rd_en   = 1'b1;
    for (int i = 0; i < 3; i++) store(32'h300 + 32'(4 * i), 32'hC0000000 + 32'(i));
    check("t5_count_queued", 32'(bus.sb_count), 32'd3);
    check("t5_rd_data_pre", bus.rd_data, 32'hA0000000);
    bus.rd_en = 1'b0;
    cyc();
    check("t5_count_draining", 32'(bus.sb_count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_count", 32'(bus.sb_count), 32'd0);
    check("t5_rst_stall", 32'(bus.stall_out), 32'd0);
    check("t5_rst_rd_data", bus.rd_data, 32'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // 6: address bits above the index alias onto low words
    store(32'h1000, 32'h5A5A5A5A);
    idle(3);
    load("t6", 32'h0000, 32'h5A5A5A5A, 0);

    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
